// File: rtl/vx_alu_commit_arb_if.sv
// Commit-arbiter bundle: NUM_INPUTS ALU commit streams in, one merged commit stream out.
// master drives the inputs and ready_out (ALU side / sink); slave is the arbiter.
interface vx_alu_commit_arb_if #(
    parameter int NUM_INPUTS = 2,
    parameter int DATAW      = 64
);
    localparam int SELW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic [NUM_INPUTS-1:0]       valid_in;
    logic [NUM_INPUTS*DATAW-1:0] data_in;
    logic [NUM_INPUTS-1:0]       sop_in;
    logic [NUM_INPUTS-1:0]       eop_in;
    logic [NUM_INPUTS-1:0]       ready_in;

    logic                        valid_out;
    logic [DATAW-1:0]            data_out;
    logic                        sop_out;
    logic                        eop_out;
    logic [SELW-1:0]             sel_out;
    logic                        ready_out;

    modport master (
        output valid_in, data_in, sop_in, eop_in, ready_out,
        input  ready_in, valid_out, data_out, sop_out, eop_out, sel_out
    );

    modport slave (
        input  valid_in, data_in, sop_in, eop_in, ready_out,
        output ready_in, valid_out, data_out, sop_out, eop_out, sel_out
    );
endinterface

// File: rtl/vx_alu_commit_arb.sv
// Packet-aware round-robin merge of ALU commit streams into a 2-entry registered skid buffer.
// Optional stall counter port perf_stalls is built only when VX_COMMIT_ARB_PERF_EN is defined.
module vx_alu_commit_arb #(
    parameter int NUM_INPUTS = 2,
    parameter int DATAW      = 64,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_alu_commit_arb_if.slave    bus
`ifdef VX_COMMIT_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_stalls
`endif
);
    localparam int SELW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_e;

    state_e          state_q;
    logic [SELW-1:0] lock_q;
    logic [SELW-1:0] rr_ptr_q;

    logic [DATAW-1:0] din [NUM_INPUTS];

    logic [SELW-1:0]       grant_idx;
    logic                  grant_vld;
    logic [SELW-1:0]       cand_idx;
    int                    cand;
    logic [NUM_INPUTS-1:0] ready_vec;
    logic                  can_accept;
    logic                  push;
    logic                  pop;

    logic [DATAW-1:0] push_data;
    logic             push_sop;
    logic             push_eop;

    // Skid buffer: head drives the outputs directly, tail catches the second beat.
    logic [1:0]       count_q, count_d;
    logic [DATAW-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic             head_sop_q, head_sop_d, tail_sop_q, tail_sop_d;
    logic             head_eop_q, head_eop_d, tail_eop_q, tail_eop_d;
    logic [SELW-1:0]  head_sel_q, head_sel_d, tail_sel_q, tail_sel_d;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_unpack
        assign din[g] = bus.data_in[g*DATAW +: DATAW];
    end

    assign can_accept = (count_q != 2'd2);

    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        if (state_q == S_LOCKED) begin
            // The lock holder keeps the grant even while it has nothing to send.
            grant_idx = lock_q;
            grant_vld = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_INPUTS; i++) begin
                cand     = (int'(rr_ptr_q) + i) % NUM_INPUTS;
                cand_idx = SELW'(cand);
                if (!grant_vld && bus.valid_in[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        if (grant_vld && can_accept && !reset) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    assign bus.ready_in = ready_vec;
    assign push         = |(bus.valid_in & ready_vec);
    assign pop          = (count_q != 2'd0) && bus.ready_out;
    assign push_data    = din[grant_idx];
    assign push_sop     = bus.sop_in[grant_idx];
    assign push_eop     = bus.eop_in[grant_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lock_q   <= '0;
            rr_ptr_q <= SELW'(NUM_INPUTS - 1);
        end else if (push) begin
            if (push_eop) begin
                rr_ptr_q <= grant_idx;
                state_q  <= S_IDLE;
            end else begin
                lock_q   <= grant_idx;
                state_q  <= S_LOCKED;
            end
        end
    end

    always_comb begin
        head_data_d = head_data_q;
        head_sop_d  = head_sop_q;
        head_eop_d  = head_eop_q;
        head_sel_d  = head_sel_q;
        tail_data_d = tail_data_q;
        tail_sop_d  = tail_sop_q;
        tail_eop_d  = tail_eop_q;
        tail_sel_d  = tail_sel_q;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};

        if (pop && (count_q == 2'd2)) begin
            head_data_d = tail_data_q;
            head_sop_d  = tail_sop_q;
            head_eop_d  = tail_eop_q;
            head_sel_d  = tail_sel_q;
        end

        // A push lands in head when head is empty or is being drained this cycle.
        if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
                head_data_d = push_data;
                head_sop_d  = push_sop;
                head_eop_d  = push_eop;
                head_sel_d  = grant_idx;
            end else begin
                tail_data_d = push_data;
                tail_sop_d  = push_sop;
                tail_eop_d  = push_eop;
                tail_sel_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= 2'd0;
            head_data_q <= '0;
            head_sop_q  <= 1'b0;
            head_eop_q  <= 1'b0;
            head_sel_q  <= '0;
            tail_data_q <= '0;
            tail_sop_q  <= 1'b0;
            tail_eop_q  <= 1'b0;
            tail_sel_q  <= '0;
        end else begin
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_sop_q  <= head_sop_d;
            head_eop_q  <= head_eop_d;
            head_sel_q  <= head_sel_d;
            tail_data_q <= tail_data_d;
            tail_sop_q  <= tail_sop_d;
            tail_eop_q  <= tail_eop_d;
            tail_sel_q  <= tail_sel_d;
        end
    end

    assign bus.valid_out = (count_q != 2'd0);
    assign bus.data_out  = head_data_q;
    assign bus.sop_out   = head_sop_q;
    assign bus.eop_out   = head_eop_q;
    assign bus.sel_out   = head_sel_q;

`ifdef VX_COMMIT_ARB_PERF_EN
    logic [PERF_W-1:0] perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else if ((|bus.valid_in) && !push) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign perf_stalls = perf_q;
`else
    localparam int unused_perf_w = PERF_W;
`endif

endmodule
